// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word over valid/ready and
// emits it one bit per enabled clock, optionally followed by an idle gap.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [7:0]    LAST_GAP = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [7:0]       gap_cnt, gap_cnt_n;
  logic             out_n, out_valid_n;
  logic             accept;

  function automatic logic end_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // State and datapath registers; enb=0 freezes everything including out/out_valid.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else if (enb) begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      out       <= out_n;
      out_valid <= out_valid_n;
    end
  end

  assign accept = enb & load_valid & load_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n   = ST_SHIFT;
          shreg_n   = data_in;
          bit_cnt_n = '0;
        end
      end
      ST_SHIFT: begin
        shreg_n   = shift_once(shreg);
        bit_cnt_n = bit_cnt + 1'b1;
        if (done) begin
          bit_cnt_n = '0;
          if (GAP > 0) begin
            state_n   = ST_GAP;
            gap_cnt_n = '0;
          end else if (accept) begin
            shreg_n = data_in;  // back-to-back word, no bubble
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_n = gap_cnt + 1'b1;
        if (gap_cnt == LAST_GAP) begin
          state_n   = ST_IDLE;
          gap_cnt_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Output register is loaded with the bit that the next state presents.
    out_valid_n = (state_n == ST_SHIFT);
    out_n       = out_valid_n & end_bit(shreg_n);
  end

  always_comb begin
    done       = (state == ST_SHIFT) && (bit_cnt == LAST_BIT);
    busy       = (state != ST_IDLE);
    load_ready = !rst && ((state == ST_IDLE) || (done && (GAP == 0)));
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench: three transmitter variants (LSB-first, MSB-first, GAP=3) share
// stimulus and are compared every cycle against a queue-based stream model.
module tb_piso_shift_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         enb;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic [2:0]   ready_w, out_w, ov_w, busy_w, done_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(0)) u_lsb (
    .clk(clk), .rst(rst), .enb(enb), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_w[0]), .out(out_w[0]), .out_valid(ov_w[0]), .busy(busy_w[0]),
    .done(done_w[0]));

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(0)) u_msb (
    .clk(clk), .rst(rst), .enb(enb), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_w[1]), .out(out_w[1]), .out_valid(ov_w[1]), .busy(busy_w[1]),
    .done(done_w[1]));

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(3)) u_gap (
    .clk(clk), .rst(rst), .enb(enb), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_w[2]), .out(out_w[2]), .out_valid(ov_w[2]), .busy(busy_w[2]),
    .done(done_w[2]));

  // Model: each accepted word becomes a list of per-cycle output entries (payload bits,
  // then GAP busy-idle cycles and one final idle cycle). A variant is ready when its
  // list is empty; every enabled edge presents the next entry.
  typedef struct packed {
    logic v;
    logic b;
    logic d;
    logic bsy;
  } ent_t;

  ent_t q [3][$];
  ent_t cur [3] = '{default: '0};

  function automatic bit msb_of(input int i);
    return i == 1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 2) ? 3 : 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 3; i++) begin
          q[i].delete();
          cur[i] = '0;
        end
      end else if (enb) begin
        for (int i = 0; i < 3; i++) begin
          if (load_valid && q[i].size() == 0) begin
            for (int k = 0; k < W; k++) begin
              ent_t e;
              e.v   = 1'b1;
              e.b   = msb_of(i) ? data_in[W-1-k] : data_in[k];
              e.d   = (k == W - 1);
              e.bsy = 1'b1;
              q[i].push_back(e);
            end
            if (gap_of(i) > 0) begin
              for (int g = 0; g < gap_of(i); g++) q[i].push_back(4'b0001);
              q[i].push_back(4'b0000);
            end
          end
          cur[i] = (q[i].size() > 0) ? q[i].pop_front() : ent_t'(4'b0000);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.out", i),        32'(out_w[i]),   32'(cur[i].b));
      check($sformatf("u%0d.out_valid", i),  32'(ov_w[i]),    32'(cur[i].v));
      check($sformatf("u%0d.done", i),       32'(done_w[i]),  32'(cur[i].d));
      check($sformatf("u%0d.busy", i),       32'(busy_w[i]),  32'(cur[i].bsy));
      check($sformatf("u%0d.load_ready", i), 32'(ready_w[i]),
            32'(!rst && q[i].size() == 0));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_all();
    end
  end

  task automatic idle_cycles(input int n);
    load_valid = 1'b0;
    enb        = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_one(input logic [W-1:0] d);
    data_in    = d;
    load_valid = 1'b1;
    enb        = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  logic       lsb_out [20];
  logic       lsb_ov  [20];
  logic       gap_ov  [20];
  logic       frozen;
  int         gap_lows;

  initial begin
    rst        = 1'b1;
    enb        = 1'b0;
    load_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(negedge clk);
    check("ready_in_reset", 32'(ready_w), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", 32'(ready_w), 32'h7);

    // LSB-first and MSB-first bit order for A5 and 0F.
    send_one(8'hA5);
    idle_cycles(15);
    send_one(8'h0F);
    idle_cycles(15);

    // Back-to-back FF then 00 with load_valid held; gap variant shows its idle run.
    data_in    = 8'hFF;
    load_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) data_in = 8'h00;
      lsb_out[k] = out_w[0];
      lsb_ov[k]  = ov_w[0];
      gap_ov[k]  = ov_w[2];
    end
    load_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("b2b_valid[%0d]", k), 32'(lsb_ov[k]), 32'd1);
      check($sformatf("b2b_bit[%0d]", k), 32'(lsb_out[k]), 32'(k < 8));
    end
    gap_lows = 0;
    for (int k = 0; k < 20; k++) if (!gap_ov[k]) gap_lows++;
    check("gap_idle_cycles", 32'(gap_lows), 32'd4);
    idle_cycles(25);

    // Clock-enable freeze in the middle of C3.
    send_one(8'hC3);
    repeat (2) @(negedge clk);
    frozen = out_w[0];
    enb    = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("freeze_out", 32'(out_w[0]), 32'(frozen));
      check("freeze_valid", 32'(ov_w[0]), 32'd1);
    end
    idle_cycles(15);

    // Asynchronous reset after the third bit of 5A.
    send_one(8'h5A);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(ov_w), 32'd0);
    check("async_rst_busy", 32'(busy_w), 32'd0);
    check("async_rst_out", 32'(out_w), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(ready_w[0]), 32'd1);
    idle_cycles(12);

    // Randomised traffic: sporadic enable, valid and data.
    for (int c = 0; c < 800; c++) begin
      enb        = ($urandom_range(0, 9) != 0);
      load_valid = ($urandom_range(0, 1) != 0);
      data_in    = W'($urandom);
      @(negedge clk);
    end
    idle_cycles(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
